pow_sched: RTL and testbench

Round-robin scheduler that shares one fixed-latency fifth-power pipeline (`pow`, latency LAT) among N requesters. It accepts at most one operand per cycle and drives the pipeline's `num` input. It tracks each in-flight operation with an ID tag that travels alongside the pipeline, and returns each registered result only to the requester that issued it. It sits between the requesting engines and the shared `pow` instance.

---
 rtl/pow_sched.sv | 129 ++++++++++++
 tb/tb_pow_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pow_sched.sv
// Round-robin front end that shares one fixed-latency fifth-power pipeline among N requesters.
// Define POW_SCHED_STATS_EN to add saturating per-requester grant counters on stat_cnt.
module pow_sched #(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int LAT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_num,
    output logic [N-1:0]     req_ready,
    input  logic             hold,
    output logic [W-1:0]     pow_num,
    input  logic [5*W-1:0]   pow_result,
    output logic [N-1:0]     rsp_valid,
    output logic [5*W-1:0]   rsp_data,
    output logic             busy
`ifdef POW_SCHED_STATS_EN
    ,
    output logic [N*16-1:0]  stat_cnt
`endif
);

    localparam int PW = $clog2(N);

    logic [PW-1:0]  r_ptr;
    logic [LAT-1:0] r_tag_v;
    logic [PW-1:0]  r_tag_id [LAT];

    logic           w_found;
    logic [PW-1:0]  w_gnt;
    logic [PW-1:0]  w_idx;

    function automatic logic [N-1:0] f_onehot(input logic [PW-1:0] id);
        logic [N-1:0] v;
        v     = {N{1'b0}};
        v[id] = 1'b1;
        return v;
    endfunction

    // Rotating priority search starting at r_ptr; the first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = {PW{1'b0}};
        w_idx   = {PW{1'b0}};
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N);
            if (!w_found && !hold && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant decode and operand mux toward the shared pipeline.
    always_comb begin
        req_ready = {N{1'b0}};
        pow_num   = {W{1'b0}};
        if (w_found) begin
            req_ready[w_gnt] = 1'b1;
            pow_num          = req_num[int'(w_gnt)*W +: W];
        end else begin
            req_ready = {N{1'b0}};
        end
    end

    // Pointer, tag line shadowing the pipeline, and the registered response stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= {PW{1'b0}};
            r_tag_v   <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                r_tag_id[i] <= {PW{1'b0}};
            end
            rsp_valid <= {N{1'b0}};
            rsp_data  <= {(5*W){1'b0}};
        end else begin
            if (w_found) begin
                r_ptr <= (w_gnt == PW'(N-1)) ? {PW{1'b0}} : w_gnt + PW'(1);
            end else begin
                r_ptr <= r_ptr;
            end
            r_tag_v[0]  <= w_found;
            r_tag_id[0] <= w_gnt;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
            if (r_tag_v[LAT-1]) begin
                rsp_valid <= f_onehot(r_tag_id[LAT-1]);
                rsp_data  <= pow_result;
            end else begin
                rsp_valid <= {N{1'b0}};
                rsp_data  <= rsp_data;
            end
        end
    end

    assign busy = (|r_tag_v) | (|rsp_valid);

`ifdef POW_SCHED_STATS_EN
    logic [15:0] r_stat [N];

    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_stat[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_found && (w_gnt == PW'(i)) && (r_stat[i] != 16'hFFFF)) begin
                    r_stat[i] <= r_stat[i] + 16'd1;
                end else begin
                    r_stat[i] <= r_stat[i];
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stat
        assign stat_cnt[g*16 +: 16] = r_stat[g];
    end
`endif

endmodule

// File: tb/tb_pow_sched.sv
// Self-checking bench for pow_sched: table of single-shot vectors plus multi-cycle sequences,
// with a reference pipeline model and a response scoreboard.
module tb_pow_sched;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int LAT = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_num;
    logic [N-1:0]     req_ready;
    logic             hold;
    logic [W-1:0]     pow_num;
    logic [5*W-1:0]   pow_result;
    logic [N-1:0]     rsp_valid;
    logic [5*W-1:0]   rsp_data;
    logic             busy;
`ifdef POW_SCHED_STATS_EN
    logic [N*16-1:0]  stat_cnt;
    int               m_cnt [N];
`endif

    pow_sched #(.W(W), .N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_num(req_num),
        .req_ready(req_ready), .hold(hold), .pow_num(pow_num),
        .pow_result(pow_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy)
`ifdef POW_SCHED_STATS_EN
        , .stat_cnt(stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   ready;
        logic [5*W-1:0] data;
        int             due;
    } exp_t;

    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] nums;
        logic           h;
        logic [N-1:0]   er;
        logic [5*W-1:0] ed;
    } vec_t;

    exp_t           sbq [$];
    exp_t           e_pop;
    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    logic [N-1:0]   e_ready = '0;
    logic [W-1:0]   e_num   = '0;
    logic [1:0]     m_ptr   = 2'd0;
    logic [5*W-1:0] p_pipe [LAT];

    function automatic logic [39:0] p5(input logic [7:0] x);
        logic [39:0] y;
        y = {32'd0, x};
        return y * y * y * y * y;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference fifth-power pipeline sharing the scheduler's reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) p_pipe[i] <= '0;
        end else begin
            p_pipe[0] <= p5(pow_num);
            for (int i = 1; i < LAT; i++) p_pipe[i] <= p_pipe[i-1];
        end
    end
    assign pow_result = p_pipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Grant/operand checks and scoreboard matching, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("pow_num", 64'(pow_num), 64'(e_num));
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL rsp_missing: got no pulse expected rsp_valid=%b data=%0d by cycle %0d",
                         sbq[0].ready, sbq[0].data, sbq[0].due);
                void'(sbq.pop_front());
            end
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%b expected 0 (cycle %0d)", rsp_valid, cyc);
                end else begin
                    e_pop = sbq.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(e_pop.ready));
                    chk("rsp_data", 64'(rsp_data), 64'(e_pop.data));
                    chk("rsp_cycle", 64'(cyc), 64'(e_pop.due));
                end
            end
        end
    end

    task automatic drive_exp(input logic [N-1:0] v, input logic [N*W-1:0] nums, input logic h,
                             input logic [N-1:0] er, input logic [5*W-1:0] ed);
        exp_t x;
        @(posedge clk);
        #1;
        req_valid = v;
        req_num   = nums;
        hold      = h;
        e_ready   = er;
        e_num     = '0;
        for (int i = 0; i < N; i++) begin
            if (er[i]) begin
                e_num = nums[i*W +: W];
                m_ptr = (i == N-1) ? 2'd0 : 2'(i + 1);
`ifdef POW_SCHED_STATS_EN
                if (m_cnt[i] < 65535) m_cnt[i]++;
`endif
            end
        end
        if (er != '0) begin
            x.ready = er;
            x.data  = ed;
            x.due   = cyc + LAT + 1;
            sbq.push_back(x);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] nums, input logic h);
        logic [N-1:0]   er;
        logic [5*W-1:0] ed;
        int             idx;
        er = '0;
        ed = '0;
        if (!h) begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(m_ptr) + k) % N;
                if (er == '0 && v[idx]) begin
                    er[idx] = 1'b1;
                    ed      = p5(nums[idx*W +: W]);
                end
            end
        end
        drive_exp(v, nums, h, er, ed);
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, '0, 1'b0);
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{4'b0010, {8'd0, 8'd0, 8'd3, 8'd0},   1'b0, 4'b0010, 40'd243};
        tbl[1] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd255}, 1'b0, 4'b0001, 40'd1078203909375};
        tbl[2] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd0},   1'b0, 4'b0001, 40'd0};
        tbl[3] = '{4'b0101, {8'd0, 8'd9, 8'd0, 8'd7},   1'b0, 4'b0100, 40'd59049};
        tbl[4] = '{4'b1001, {8'd10, 8'd0, 8'd0, 8'd1},  1'b0, 4'b1000, 40'd100000};
        tbl[5] = '{4'b1111, {8'd1, 8'd1, 8'd1, 8'd1},   1'b1, 4'b0000, 40'd0};
        tbl[6] = '{4'b1100, {8'd4, 8'd2, 8'd0, 8'd0},   1'b0, 4'b0100, 40'd32};
        tbl[7] = '{4'b0000, {8'd0, 8'd0, 8'd0, 8'd0},   1'b0, 4'b0000, 40'd0};

        req_valid = '0;
        req_num   = '0;
        hold      = 1'b0;
`ifdef POW_SCHED_STATS_EN
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_pow_num", 64'(pow_num), 64'd0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            drive_exp(tbl[i].v, tbl[i].nums, tbl[i].h, tbl[i].er, tbl[i].ed);
            idle(LAT + 2);
        end

        // Pointer sits at 3: one grant to requester 3 wraps it back to 0.
        drive(4'b1000, '0, 1'b0);
        idle(LAT + 2);

        repeat (4) drive(4'b1111, {8'd5, 8'd4, 8'd3, 8'd2}, 1'b0);
        idle(LAT + 3);

        repeat (6) drive(4'b0101, {8'd0, 8'd6, 8'd0, 8'd8}, 1'b0);
        @(negedge clk);
        chk("busy_active", 64'(busy), 64'd1);
        repeat (3) drive(4'b0101, {8'd0, 8'd6, 8'd0, 8'd8}, 1'b1);
        repeat (LAT) drive(4'b0101, {8'd0, 8'd6, 8'd0, 8'd8}, 1'b1);
        @(negedge clk);
        chk("busy_drained", 64'(busy), 64'd0);
        idle(2);

        repeat (3) drive(4'b0111, {8'd0, 8'd3, 8'd2, 8'd1}, 1'b0);
        idle(2);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        e_ready   = '0;
        e_num     = '0;
        m_ptr     = 2'd0;
        sbq.delete();
`ifdef POW_SCHED_STATS_EN
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(LAT + 3);
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        drive(4'b1111, {8'd4, 8'd3, 8'd2, 8'd6}, 1'b0);
        idle(LAT + 3);

`ifdef POW_SCHED_STATS_EN
        repeat (70000) drive(4'b1000, {8'd1, 8'd0, 8'd0, 8'd0}, 1'b0);
        idle(LAT + 3);
        chk("stat_cnt3", 64'(stat_cnt[3*16 +: 16]), 64'h0000_0000_0000_FFFF);
        for (int i = 0; i < N - 1; i++) begin
            chk("stat_cnt", 64'(stat_cnt[i*16 +: 16]), 64'(m_cnt[i]));
        end
`endif

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
